month_year: RTL and testbench

- Calendar stage directly downstream of the day counter in the millennium clock.
- Consumes the day-rollover pulse and keeps month (1..12) and year (0000..9999, 4-digit BCD).
- Drives month_bin, leap_year and max_day back to the day counter.
- Supports manual month/year adjust using synchronised, edge-detected up/down buttons, all on the single 1 Hz-domain clock.

---
 rtl/clock_pkg.sv | 43 ++++
 rtl/bcd4_incdec.sv | 51 +++++
 rtl/month_year.sv | 122 ++++++++++++
 tb/tb_month_year.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared calendar definitions for the millennium clock: month and
// day-count constants, the BCD digit type and small calendar helpers.
package clock_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam logic [3:0] MONTH_JAN = 4'd1;
   localparam logic [3:0] MONTH_FEB = 4'd2;
   localparam logic [3:0] MONTH_MAR = 4'd3;
   localparam logic [3:0] MONTH_APR = 4'd4;
   localparam logic [3:0] MONTH_MAY = 4'd5;
   localparam logic [3:0] MONTH_JUN = 4'd6;
   localparam logic [3:0] MONTH_JUL = 4'd7;
   localparam logic [3:0] MONTH_AUG = 4'd8;
   localparam logic [3:0] MONTH_SEP = 4'd9;
   localparam logic [3:0] MONTH_OCT = 4'd10;
   localparam logic [3:0] MONTH_NOV = 4'd11;
   localparam logic [3:0] MONTH_DEC = 4'd12;

   localparam logic [4:0] DAYS_28 = 5'd28;
   localparam logic [4:0] DAYS_29 = 5'd29;
   localparam logic [4:0] DAYS_30 = 5'd30;
   localparam logic [4:0] DAYS_31 = 5'd31;

   // Two-digit BCD value TU divisible by 4: even tens need units 0/4/8,
   // odd tens need units 2/6.
   function automatic logic bcd2_div4(input bcd_digit_t tens, input bcd_digit_t units);
      if (tens[0])
         return (units == 4'd2) || (units == 4'd6);
      else
         return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
   endfunction

   // Length of a month, February depending on the leap flag.
   function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
      case (month)
         MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV: return DAYS_30;
         MONTH_FEB: return leap ? DAYS_29 : DAYS_28;
         default:   return DAYS_31;
      endcase
   endfunction

endpackage

// File: rtl/bcd4_incdec.sv
// Four-digit BCD incrementer/decrementer with wrap at 9999 <-> 0000.
// Passes the value through unchanged when neither or both requests are set.
module bcd4_incdec
   import clock_pkg::*;
(
   input  logic [15:0] value_in,
   input  logic        inc,
   input  logic        dec,
   output logic [15:0] value_out,
   output logic        wrap
);

   bcd_digit_t digit;
   logic       ripple;

   // Digit-serial ripple: each digit steps only while every lower digit wrapped.
   always_comb begin
      value_out = value_in;
      wrap      = 1'b0;
      ripple    = 1'b1;
      digit     = 4'd0;
      if (inc && !dec) begin
         for (int i = 0; i < 4; i++) begin
            digit = value_in[4*i +: 4];
            if (ripple) begin
               if (digit == 4'd9) begin
                  value_out[4*i +: 4] = 4'd0;
               end else begin
                  value_out[4*i +: 4] = digit + 4'd1;
                  ripple = 1'b0;
               end
            end
         end
         wrap = ripple;
      end else if (dec && !inc) begin
         for (int i = 0; i < 4; i++) begin
            digit = value_in[4*i +: 4];
            if (ripple) begin
               if (digit == 4'd0) begin
                  value_out[4*i +: 4] = 4'd9;
               end else begin
                  value_out[4*i +: 4] = digit - 4'd1;
                  ripple = 1'b0;
               end
            end
         end
         wrap = ripple;
      end
   end

endmodule

// File: rtl/month_year.sv
// Month/year calendar stage: advances on day rollover, supports manual
// month/year adjust from synchronised edge-detected buttons, and reports
// leap-year and month length back to the day counter.
module month_year
   import clock_pkg::*;
#(
   parameter int          RESET_MONTH = 1,
   parameter logic [15:0] RESET_YEAR  = 16'h2000
)(
   input  logic        clk_1Hz,
   input  logic        rst_n,
   input  logic        en_1,
   input  logic        carry_in,
   input  logic        adjust,
   input  logic        sel,
   input  logic        up,
   input  logic        down,
   output logic [3:0]  month_bin,
   output logic [15:0] year_bcd,
   output logic        leap_year,
   output logic [4:0]  max_day,
   output logic        carry_out
);

   logic        up_s1_q, up_s1_d, up_s2_q, up_s2_d, up_dly_q, up_dly_d;
   logic        dn_s1_q, dn_s1_d, dn_s2_q, dn_s2_d, dn_dly_q, dn_dly_d;
   logic        up_pulse, dn_pulse, count_trig;
   logic [3:0]  month_q, month_d;
   logic [15:0] year_q, year_d;
   logic        carry_out_q, carry_out_d;
   logic        year_inc, year_dec, year_wrap;

   // Button synchronisers and delay flops feeding the rising-edge detectors.
   always_comb begin
      up_s1_d  = up;
      up_s2_d  = up_s1_q;
      up_dly_d = up_s2_q;
      dn_s1_d  = down;
      dn_s2_d  = dn_s1_q;
      dn_dly_d = dn_s2_q;
   end

   assign up_pulse   = up_s2_q & ~up_dly_q;
   assign dn_pulse   = dn_s2_q & ~dn_dly_q;
   assign count_trig = ~adjust & en_1 & carry_in;

   // Year step requests: December rollover in count mode, or a lone button
   // pulse with the year field selected in adjust mode.
   always_comb begin
      year_inc = 1'b0;
      year_dec = 1'b0;
      if (count_trig) begin
         year_inc = (month_q == MONTH_DEC);
      end else if (adjust && sel && (up_pulse ^ dn_pulse)) begin
         year_inc = up_pulse;
         year_dec = dn_pulse;
      end
   end

   bcd4_incdec u_year (
      .value_in  (year_q),
      .inc       (year_inc),
      .dec       (year_dec),
      .value_out (year_d),
      .wrap      (year_wrap)
   );

   // Month next-state; carry_out only flags the count-mode millennium wrap.
   always_comb begin
      month_d     = month_q;
      carry_out_d = count_trig & year_wrap;
      if (count_trig) begin
         month_d = (month_q == MONTH_DEC) ? MONTH_JAN : month_q + 4'd1;
      end else if (adjust && !sel && (up_pulse ^ dn_pulse)) begin
         if (up_pulse)
            month_d = (month_q == MONTH_DEC) ? MONTH_JAN : month_q + 4'd1;
         else
            month_d = (month_q == MONTH_JAN) ? MONTH_DEC : month_q - 4'd1;
      end
   end

   // State registers; reset also clears the button pipelines so that a
   // pending edge is discarded.
   always_ff @(posedge clk_1Hz or negedge rst_n) begin
      if (!rst_n) begin
         up_s1_q     <= 1'b0;
         up_s2_q     <= 1'b0;
         up_dly_q    <= 1'b0;
         dn_s1_q     <= 1'b0;
         dn_s2_q     <= 1'b0;
         dn_dly_q    <= 1'b0;
         month_q     <= 4'(RESET_MONTH);
         year_q      <= RESET_YEAR;
         carry_out_q <= 1'b0;
      end else begin
         up_s1_q     <= up_s1_d;
         up_s2_q     <= up_s2_d;
         up_dly_q    <= up_dly_d;
         dn_s1_q     <= dn_s1_d;
         dn_s2_q     <= dn_s2_d;
         dn_dly_q    <= dn_dly_d;
         month_q     <= month_d;
         year_q      <= year_d;
         carry_out_q <= carry_out_d;
      end
   end

   // Simulation guard: catches an out-of-range RESET_MONTH or a corrupted month.
   always_ff @(posedge clk_1Hz) begin
      if (rst_n)
         assert (month_q >= MONTH_JAN && month_q <= MONTH_DEC)
            else $error("month_bin out of range: %0d", month_q);
   end

   assign leap_year = (year_q[7:0] == 8'h00) ? bcd2_div4(year_q[15:12], year_q[11:8])
                                             : bcd2_div4(year_q[7:4], year_q[3:0]);
   assign max_day   = days_in_month(month_q, leap_year);
   assign month_bin = month_q;
   assign year_bcd  = year_q;
   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_month_year.sv
// Randomised self-checking bench for month_year with a decimal calendar model.
module tb_month_year;

   logic        clk_1Hz = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_1 = 1'b0, carry_in = 1'b0, adjust = 1'b0, sel = 1'b0;
   logic        up = 1'b0, down = 1'b0;
   logic [3:0]  month_bin;
   logic [15:0] year_bcd;
   logic        leap_year;
   logic [4:0]  max_day;
   logic        carry_out;

   int checks = 0;
   int failures = 0;

   // Model state: plain decimal month/year.
   int m_month = 1;
   int m_year = 2000;
   bit m_co = 1'b0;
   bit hu[3] = '{0, 0, 0};
   bit hd[3] = '{0, 0, 0};
   int dim[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

   month_year #(.RESET_MONTH(1), .RESET_YEAR(16'h2000)) dut (
      .clk_1Hz   (clk_1Hz),
      .rst_n     (rst_n),
      .en_1      (en_1),
      .carry_in  (carry_in),
      .adjust    (adjust),
      .sel       (sel),
      .up        (up),
      .down      (down),
      .month_bin (month_bin),
      .year_bcd  (year_bcd),
      .leap_year (leap_year),
      .max_day   (max_day),
      .carry_out (carry_out)
   );

   always #5 clk_1Hz = ~clk_1Hz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int y);
      logic [15:0] r;
      r[15:12] = 4'(y / 1000);
      r[11:8]  = 4'((y / 100) % 10);
      r[7:4]   = 4'((y / 10) % 10);
      r[3:0]   = 4'(y % 10);
      return r;
   endfunction

   function automatic bit is_leap(input int y);
      return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
   endfunction

   function automatic int days_of(input int m, input int y);
      return dim[m-1] + ((m == 2 && is_leap(y)) ? 1 : 0);
   endfunction

   // Model update on each rising edge, then compare all outputs just after it.
   always @(posedge clk_1Hz) begin
      bit pu, pd;
      m_co = 1'b0;
      if (!rst_n) begin
         m_month = 1;
         m_year  = 2000;
         hu = '{0, 0, 0};
         hd = '{0, 0, 0};
      end else begin
         pu = hu[1] & ~hu[2];
         pd = hd[1] & ~hd[2];
         if (!adjust) begin
            if (en_1 && carry_in) begin
               if (m_month < 12) m_month++;
               else begin
                  m_month = 1;
                  if (m_year == 9999) begin
                     m_year = 0;
                     m_co = 1'b1;
                  end else m_year++;
               end
            end
         end else if (pu != pd) begin
            if (sel) m_year = pu ? (m_year + 1) % 10000 : (m_year + 9999) % 10000;
            else     m_month = pu ? (m_month % 12) + 1 : ((m_month + 10) % 12) + 1;
         end
         hu[2] = hu[1]; hu[1] = hu[0]; hu[0] = up;
         hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = down;
      end
      #1;
      chk("month_bin", 32'(month_bin), 32'(m_month));
      chk("year_bcd", 32'(year_bcd), 32'(to_bcd(m_year)));
      chk("leap_year", 32'(leap_year), 32'(is_leap(m_year)));
      chk("max_day", 32'(max_day), 32'(days_of(m_month, m_year)));
      chk("carry_out", 32'(carry_out), 32'(m_co));
   end

   task automatic press(input bit is_up);
      if (is_up) up = 1'b1; else down = 1'b1;
      @(negedge clk_1Hz);
      up = 1'b0;
      down = 1'b0;
      repeat (2) @(negedge clk_1Hz);
   endtask

   task automatic goto_month(input int m);
      adjust = 1'b1;
      sel = 1'b0;
      for (int i = 0; i < 12 && m_month != m; i++) press(1'b1);
   endtask

   task automatic goto_year(input int y);
      int d;
      adjust = 1'b1;
      sel = 1'b1;
      d = (y - m_year + 10000) % 10000;
      if (d <= 5000) for (int i = 0; i < d; i++) press(1'b1);
      else for (int i = 0; i < 10000 - d; i++) press(1'b0);
   endtask

   task automatic day_pulse();
      en_1 = 1'b1;
      carry_in = 1'b1;
      @(negedge clk_1Hz);
      carry_in = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk_1Hz);
      // 1: reset state
      chk("rst_month", 32'(month_bin), 32'd1);
      chk("rst_year", 32'(year_bcd), 32'h2000);
      chk("rst_leap", 32'(leap_year), 32'd1);
      chk("rst_maxday", 32'(max_day), 32'd31);
      chk("rst_co", 32'(carry_out), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_1Hz);

      // 2: December 1999 rolls into January 2000
      goto_month(12);
      goto_year(1999);
      adjust = 1'b0;
      @(negedge clk_1Hz);
      day_pulse();
      chk("t2_month", 32'(month_bin), 32'd1);
      chk("t2_year", 32'(year_bcd), 32'h2000);
      chk("t2_co", 32'(carry_out), 32'd0);
      goto_month(2);
      chk("t2_feb_leap", 32'(max_day), 32'd29);

      // 3: millennium wrap
      goto_month(12);
      goto_year(9999);
      adjust = 1'b0;
      @(negedge clk_1Hz);
      day_pulse();
      chk("t3_co_hi", 32'(carry_out), 32'd1);
      chk("t3_year", 32'(year_bcd), 32'h0000);
      chk("t3_month", 32'(month_bin), 32'd1);
      chk("t3_leap0000", 32'(leap_year), 32'd1);
      @(negedge clk_1Hz);
      chk("t3_co_lo", 32'(carry_out), 32'd0);

      // 4: year adjust around 1900
      goto_year(1900);
      press(1'b0);
      chk("t4_down", 32'(year_bcd), 32'h1899);
      press(1'b1);
      press(1'b1);
      chk("t4_up2", 32'(year_bcd), 32'h1901);
      press(1'b0);
      goto_month(2);
      chk("t4_1900_feb", 32'(max_day), 32'd28);
      chk("t4_1900_leap", 32'(leap_year), 32'd0);
      sel = 1'b1;
      up = 1'b1;
      repeat (10) @(negedge clk_1Hz);
      up = 1'b0;
      repeat (2) @(negedge clk_1Hz);
      chk("t4_hold", 32'(year_bcd), 32'h1901);

      // 5: month adjust wrap, simultaneous buttons, carry ignored
      goto_month(1);
      press(1'b0);
      chk("t5_dec_wrap", 32'(month_bin), 32'd12);
      chk("t5_year_kept", 32'(year_bcd), 32'h1901);
      up = 1'b1;
      down = 1'b1;
      @(negedge clk_1Hz);
      up = 1'b0;
      down = 1'b0;
      repeat (2) @(negedge clk_1Hz);
      chk("t5_both", 32'(month_bin), 32'd12);
      day_pulse();
      @(negedge clk_1Hz);
      chk("t5_carry_ign", 32'(month_bin), 32'd12);
      chk("t5_co_adj", 32'(carry_out), 32'd0);

      // 6: reset mid-synchroniser
      sel = 1'b1;
      up = 1'b1;
      @(negedge clk_1Hz);
      rst_n = 1'b0;
      #1;
      chk("t6_month", 32'(month_bin), 32'd1);
      chk("t6_year", 32'(year_bcd), 32'h2000);
      up = 1'b0;
      @(negedge clk_1Hz);
      rst_n = 1'b1;
      repeat (4) @(negedge clk_1Hz);
      chk("t6_no_step", 32'(year_bcd), 32'h2000);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         en_1 = 1'($urandom_range(0, 1));
         carry_in = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) adjust = ~adjust;
         if ($urandom_range(0, 7) == 0) sel = ~sel;
         if ($urandom_range(0, 3) == 0) up = ~up;
         if ($urandom_range(0, 3) == 0) down = ~down;
         rst_n = ($urandom_range(0, 499) != 0);
         @(negedge clk_1Hz);
      end
      rst_n = 1'b1;
      @(negedge clk_1Hz);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
